// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the coordinate type shared by the
// VGA timing generator and its bench.
package vga_timing_pkg;

    typedef logic [15:0] coord_t;

    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_ACT_START = 144;
    localparam int DEF_H_ACT_END   = 783;

    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_ACT_START = 35;
    localparam int DEF_V_ACT_END   = 514;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: one registered clk-wide pulse every CLK_DIV clocks.
// The pulse follows the divider's terminal count by one register stage.
module pix_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_reg;
    logic [DW-1:0] div_next;
    logic          tick_reg;

    always_comb begin
        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            div_reg  <= div_next;
            tick_reg <= (div_reg == DIV_LAST);
        end
    end

    assign pix_tick = tick_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y counters advanced by pix_tick, with sync, active and
// line/frame pulses registered from the next-state coordinates.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_END   = DEF_H_ACT_END,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_END   = DEF_V_ACT_END
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pix_tick,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    logic   tick;
    coord_t x_reg, x_next;
    coord_t y_reg, y_next;
    coord_t frame_cnt_reg, frame_cnt_next;
    logic   hsync_reg, vsync_reg, active_reg;
    logic   line_start_reg, frame_start_reg;
    logic   h_last, v_last, line_wrap, frame_wrap;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (tick)
    );

    always_comb begin
        h_last         = (x_reg == 16'(H_TOTAL - 1));
        v_last         = (y_reg == 16'(V_TOTAL - 1));
        line_wrap      = tick && h_last;
        frame_wrap     = line_wrap && v_last;
        x_next         = x_reg;
        y_next         = y_reg;
        frame_cnt_next = frame_cnt_reg;
        if (tick) begin
            if (h_last) begin
                x_next = '0;
                y_next = v_last ? '0 : y_reg + 16'd1;
            end else begin
                x_next = x_reg + 16'd1;
            end
        end
        if (frame_wrap) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
        end
    end

    // Everything is rewritten every cycle from the next-state values, so the
    // decoded outputs can never lag the coordinates they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_reg           <= '0;
            y_reg           <= '0;
            frame_cnt_reg   <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            active_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            frame_cnt_reg   <= frame_cnt_next;
            hsync_reg       <= !(x_next < 16'(H_SYNC));
            vsync_reg       <= !(y_next < 16'(V_SYNC));
            active_reg      <= (x_next >= 16'(H_ACT_START)) && (x_next <= 16'(H_ACT_END)) &&
                               (y_next >= 16'(V_ACT_START)) && (y_next <= 16'(V_ACT_END));
            line_start_reg  <= line_wrap;
            frame_start_reg <= frame_wrap;
        end
    end

    assign pix_tick    = tick;
    assign x           = x_reg;
    assign y           = y_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance driven through preloaded
// coordinates, plus a tiny-raster CLK_DIV=1 instance run through whole frames.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_s = 1'b0;
    always #5 clk = ~clk;

    logic        pix_tick, hsync, vsync, active, line_start, frame_start;
    logic [15:0] x, y, frame_cnt;

    logic        s_pix_tick, s_hsync, s_vsync, s_active, s_line_start, s_frame_start;
    logic [15:0] s_x, s_y, s_frame_cnt;

    vga_timing_gen dut (
        .clk (clk), .reset (reset), .pix_tick (pix_tick), .x (x), .y (y),
        .hsync (hsync), .vsync (vsync), .active (active), .line_start (line_start),
        .frame_start (frame_start), .frame_cnt (frame_cnt)
    );

    vga_timing_gen #(
        .CLK_DIV (1), .H_TOTAL (10), .H_SYNC (2), .H_ACT_START (3), .H_ACT_END (8),
        .V_TOTAL (4), .V_SYNC (1), .V_ACT_START (1), .V_ACT_END (2)
    ) dut_s (
        .clk (clk), .reset (reset_s), .pix_tick (s_pix_tick), .x (s_x), .y (s_y),
        .hsync (s_hsync), .vsync (s_vsync), .active (s_active), .line_start (s_line_start),
        .frame_start (s_frame_start), .frame_cnt (s_frame_cnt)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int   px, py;
        int   ex, ey;
        logic hs, vs, act, ls, fs;
    } vec_t;

    vec_t        vecs[12];
    obs_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          fc_model = 0;
    logic [15:0] force_x, force_y, force_fc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.x = x; o.y = y; o.hs = hsync; o.vs = vsync; o.act = active;
        o.ls = line_start; o.fs = frame_start; o.fc = frame_cnt;
        return o;
    endfunction

    // Load x/y during a cycle with no tick pending, so the next edge only holds.
    task automatic preload(input int px, input int py, input bit with_fc, input int fc);
        int n = 0;
        while (pix_tick && n < 8) begin
            @(posedge clk); #1; n++;
        end
        force_x = 16'(px); force_y = 16'(py); force_fc = 16'(fc);
        force dut.x_reg = force_x;
        force dut.y_reg = force_y;
        if (with_fc) force dut.frame_cnt_reg = force_fc;
        @(posedge clk); #1;
        release dut.x_reg;
        release dut.y_reg;
        if (with_fc) release dut.frame_cnt_reg;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (!pix_tick && n < 8) begin
            @(posedge clk); #1; n++;
        end
        if (!pix_tick) check({name, "_tick_timeout"}, 64'(pix_tick), 64'd1);
    endtask

    task automatic check_release_ticks(input string name);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s_edge%0d", name, k),
                  {pix_tick, x, line_start, frame_start},
                  {(k % 2 == 0) ? 1'b1 : 1'b0, (k >= 3) ? 16'((k - 1) / 2) : 16'd0, 1'b0, 1'b0});
        end
    endtask

    initial begin
        obs_t exp_o, got_o;
        obs_t rst_o;

        vecs[0]  = '{94, 0, 95, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{95, 0, 96, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{799, 0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{799, 1, 0, 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{799, 10, 0, 11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{142, 35, 143, 35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{143, 35, 144, 35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{782, 514, 783, 514, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{783, 514, 784, 514, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{143, 34, 144, 34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{799, 514, 0, 515, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{799, 524, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_o = '{16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};

        // Reset state and tick spacing after release.
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {sample(), pix_tick}, {rst_o, 1'b0});
        reset = 1'b1;
        check_release_ticks("release");
        $display("seq release: x=%0d y=%0d", x, y);

        // Table of single-tick transitions from preloaded coordinates.
        for (int i = 0; i < 12; i++) begin
            preload(vecs[i].px, vecs[i].py, 1'b0, 0);
            if (vecs[i].fs) fc_model = (fc_model + 1) % 65536;
            exp_o = '{16'(vecs[i].ex), 16'(vecs[i].ey), vecs[i].hs, vecs[i].vs,
                      vecs[i].act, vecs[i].ls, vecs[i].fs, 16'(fc_model)};
            sb.push_back(exp_o);
            wait_tick($sformatf("vec%0d", i));
            @(posedge clk); #1;
            got_o = sample();
            exp_o = sb.pop_front();
            check($sformatf("vec%0d", i), got_o, exp_o);
            $display("vec %0d: (%0d,%0d) -> x=%0d y=%0d hs=%0b vs=%0b act=%0b ls=%0b fs=%0b fc=%0d",
                     i, vecs[i].px, vecs[i].py, x, y, hsync, vsync, active,
                     line_start, frame_start, frame_cnt);
            @(posedge clk); #1;
            check($sformatf("vec%0d_hold", i), {x, y, line_start, frame_start},
                  {exp_o.x, exp_o.y, 1'b0, 1'b0});
        end

        // Reset in the middle of a frame.
        preload(399, 200, 1'b0, 0);
        wait_tick("mid");
        @(posedge clk); #1;
        check("mid_x", {x, y}, {16'd400, 16'd200});
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_state", {sample(), pix_tick}, {rst_o, 1'b0});
        reset = 1'b1;
        check_release_ticks("mid_release");
        fc_model = 0;
        $display("seq mid-reset: x=%0d y=%0d fc=%0d", x, y, frame_cnt);

        // frame_cnt rollover on a frame wrap.
        preload(799, 524, 1'b1, 65535);
        wait_tick("fcwrap");
        @(posedge clk); #1;
        check("fc_wrap", {x, y, line_start, frame_start, frame_cnt},
              {16'd0, 16'd0, 1'b1, 1'b1, 16'd0});
        $display("seq fc wrap: fc=%0d fs=%0b", frame_cnt, frame_start);

        // Tiny raster, CLK_DIV=1: walk past the first frame wrap.
        reset_s = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            int t, ex, ey;
            logic eact, ehs, evs, els, efs;
            @(posedge clk); #1;
            t    = k - 1;
            ex   = t % 10;
            ey   = (t / 10) % 4;
            ehs  = (ex >= 2);
            evs  = (ey >= 1);
            eact = (ex >= 3 && ex <= 8 && ey >= 1 && ey <= 2);
            els  = (t > 0 && t % 10 == 0);
            efs  = (t > 0 && t % 40 == 0);
            check($sformatf("small_t%0d", t),
                  {s_pix_tick, s_x, s_y, s_hsync, s_vsync, s_active, s_line_start, s_frame_start, s_frame_cnt},
                  {1'b1, 16'(ex), 16'(ey), ehs, evs, eact, els, efs, 16'(t / 40)});
        end
        $display("seq small frame: x=%0d y=%0d fc=%0d", s_x, s_y, s_frame_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
